// File: rtl/lenet5_frame_preproc.sv
// ============================================================================
// Module   : lenet5_frame_preproc
// Purpose  : Crops a fixed ROI from a raw grayscale stream, box-averages it
//            DS x DS to an OUT_W x OUT_H image and emits signed pixels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lenet5_frame_preproc #(
  parameter int SRC_W  = 640,
  parameter int SRC_H  = 480,
  parameter int ROI_X0 = 192,
  parameter int ROI_Y0 = 112,
  parameter int DS     = 8,
  parameter int OUT_W  = 32,
  parameter int OUT_H  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_vsync,
  input  logic       s_de,
  input  logic [7:0] s_pix,
  input  logic       enable,
  output logic       lenet_start,
  output logic       lenet_v,
  output logic [7:0] lenet_pix,
  output logic [3:0] image_num,
  output logic       frame_done,
  output logic       err_short_frame
);

  localparam int c_lg   = $clog2(DS);
  localparam int c_xw   = $clog2(SRC_W + 1);
  localparam int c_yw   = $clog2(SRC_H + 1);
  localparam int c_hw   = 8 + c_lg;
  localparam int c_aw   = 8 + 2 * c_lg;
  localparam int c_cw   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int c_rw   = c_lg + c_cw;
  localparam int c_npix = OUT_W * OUT_H;
  localparam int c_pw   = $clog2(c_npix + 1);

  localparam logic [c_xw-1:0] c_x_lo  = c_xw'(ROI_X0);
  localparam logic [c_xw-1:0] c_x_hi  = c_xw'(ROI_X0 + OUT_W * DS);
  localparam logic [c_xw-1:0] c_x_max = c_xw'(SRC_W);
  localparam logic [c_yw-1:0] c_y_lo  = c_yw'(ROI_Y0);
  localparam logic [c_yw-1:0] c_y_hi  = c_yw'(ROI_Y0 + OUT_H * DS);
  localparam logic [c_yw-1:0] c_y_max = c_yw'(SRC_H);
  localparam logic [c_lg-1:0] c_s_last = c_lg'(DS - 1);
  localparam logic [c_pw-1:0] c_p_last = c_pw'(c_npix - 1);
  localparam logic [c_aw-1:0] c_round  = c_aw'(DS * DS / 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_start;
  logic             w_err;
  logic             w_done;
  logic             w_last;

  logic [c_xw-1:0]  r_x;
  logic [c_yw-1:0]  r_y;
  logic             r_de_d;
  logic [3:0]       r_frame_cnt;
  logic [c_pw-1:0]  r_pcnt;

  logic [c_rw-1:0]  w_rx;
  logic [c_lg-1:0]  w_sx;
  logic [c_lg-1:0]  w_sy;
  logic [c_cw-1:0]  w_cx;
  logic             w_take;
  logic             w_row_end;
  logic             w_blk_end;
  logic [c_hw-1:0]  w_hsum;
  logic [c_aw-1:0]  w_acc_sum;

  logic [c_hw-1:0]  r_hsum;
  logic [c_aw-1:0]  r_acc [OUT_W];
  logic             r_p1_v;
  logic [c_aw-1:0]  r_p1_total;
  logic [7:0]       w_avg;

  // Source raster position; saturates past the active area so stray pixels are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_de_d <= 1'b0;
    end else begin
      r_de_d <= s_de;
      if (s_vsync) begin
        r_x <= '0;
        r_y <= '0;
      end else if (s_de) begin
        if (r_x != c_x_max) r_x <= r_x + 1'b1;
      end else if (r_de_d) begin
        r_x <= '0;
        if (r_y != c_y_max) r_y <= r_y + 1'b1;
      end
    end
  end

  assign w_rx = c_rw'(r_x - c_x_lo);
  assign w_sx = w_rx[c_lg-1:0];
  assign w_cx = w_rx[c_lg +: c_cw];
  assign w_sy = c_lg'(r_y - c_y_lo);

  assign w_take = s_de && !s_vsync && (r_state == S_ACTIVE) &&
                  (r_x >= c_x_lo) && (r_x < c_x_hi) &&
                  (r_y >= c_y_lo) && (r_y < c_y_hi);
  assign w_row_end = w_take && (w_sx == c_s_last);
  assign w_blk_end = w_row_end && (w_sy == c_s_last);

  assign w_hsum    = ((w_sx == '0) ? '0 : r_hsum) + c_hw'(s_pix);
  assign w_acc_sum = ((w_sy == '0) ? '0 : r_acc[w_cx]) + c_aw'(w_hsum);

  // Accumulator contents are fully rebuilt by the sx==0 / sy==0 clears, so no reset.
  always_ff @(posedge clk) begin
    if (w_take) r_hsum <= w_hsum;
    if (w_row_end) r_acc[w_cx] <= w_acc_sum;
    if (w_blk_end) r_p1_total <= w_acc_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_p1_v <= 1'b0;
    else        r_p1_v <= w_blk_end;
  end

  // Block total never exceeds 255*DS*DS, so rounding cannot carry out of c_aw bits.
  assign w_avg = 8'((r_p1_total + c_round) >> (2 * c_lg));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lenet_v   <= 1'b0;
      lenet_pix <= '0;
    end else begin
      lenet_v <= r_p1_v;
      if (r_p1_v) lenet_pix <= {~w_avg[7], w_avg[6:0]};
    end
  end

  assign w_last = r_p1_v && (r_state == S_ACTIVE) && (r_pcnt == c_p_last);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_err       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (s_vsync && enable) begin
          w_state_nxt = S_ACTIVE;
          w_start     = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else if (s_vsync) begin
          w_err = 1'b1;
          if (enable) w_start = 1'b1;
          else        w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (s_vsync && enable) begin
          w_state_nxt = S_ACTIVE;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_frame_cnt     <= '0;
      r_pcnt          <= '0;
      image_num       <= '0;
      lenet_start     <= 1'b0;
      frame_done      <= 1'b0;
      err_short_frame <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      lenet_start     <= w_start;
      frame_done      <= w_done;
      err_short_frame <= w_err;
      if (w_start) begin
        image_num   <= r_frame_cnt;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if (w_start) r_pcnt <= '0;
      else if (r_p1_v && (r_state == S_ACTIVE)) r_pcnt <= r_pcnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lenet5_frame_preproc.sv
// ============================================================================
// Module   : tb_lenet5_frame_preproc
// Purpose  : Scoreboard bench for lenet5_frame_preproc on a reduced geometry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lenet5_frame_preproc;

  localparam int P_SRC_W = 40;
  localparam int P_SRC_H = 36;
  localparam int P_X0    = 5;
  localparam int P_Y0    = 3;
  localparam int P_DS    = 4;
  localparam int P_OW    = 8;
  localparam int P_OH    = 8;
  localparam int P_NPIX  = P_OW * P_OH;
  localparam int HGAP    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_vsync = 1'b0;
  logic       s_de = 1'b0;
  logic [7:0] s_pix = '0;
  logic       enable = 1'b0;
  logic       lenet_start, lenet_v, frame_done, err_short_frame;
  logic [7:0] lenet_pix;
  logic [3:0] image_num;

  lenet5_frame_preproc #(
    .SRC_W(P_SRC_W), .SRC_H(P_SRC_H), .ROI_X0(P_X0), .ROI_Y0(P_Y0),
    .DS(P_DS), .OUT_W(P_OW), .OUT_H(P_OH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_vsync(s_vsync), .s_de(s_de), .s_pix(s_pix),
    .enable(enable), .lenet_start(lenet_start), .lenet_v(lenet_v),
    .lenet_pix(lenet_pix), .image_num(image_num), .frame_done(frame_done),
    .err_short_frame(err_short_frame)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [7:0] pix; int cyc; } pexp_t;
  typedef struct packed { logic [3:0] id;  int cyc; } iexp_t;
  pexp_t pq[$];
  iexp_t iq[$];

  int total = 0;
  int bad   = 0;
  int n_start = 0, n_v = 0, n_done = 0, n_err = 0;
  int s_st, s_v, s_dn, s_er;
  int last_v_cyc = -100;
  int g_seed = 1;
  logic [3:0] m_fc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gen(input int pat, input int x, input int y);
    int v;
    bit in_roi;
    in_roi = (x >= P_X0) && (x < P_X0 + P_OW * P_DS) && (y >= P_Y0) && (y < P_Y0 + P_OH * P_DS);
    case (pat)
      0: v = 200;
      1: v = in_roi ? (x - P_X0) : 0;
      2: v = (in_roi && ((x - P_X0) / P_DS == 3) && ((y - P_Y0) / P_DS == 2)) ? 255 : 0;
      4: v = 255;
      default: v = x * 73 + y * 151 + g_seed * 29 + (x ^ y) * x;
    endcase
    return v[7:0];
  endfunction

  // Reference: direct 2-D block sum, rounded half up, then offset by -128.
  function automatic logic [7:0] exp_pix(input int pat, input int bx, input int by);
    int sum, avg;
    logic [7:0] a;
    sum = 0;
    for (int dy = 0; dy < P_DS; dy++)
      for (int dx = 0; dx < P_DS; dx++)
        sum += int'(gen(pat, P_X0 + bx * P_DS + dx, P_Y0 + by * P_DS + dy));
    avg = (sum + P_DS * P_DS / 2) / (P_DS * P_DS);
    a = avg[7:0];
    return a ^ 8'h80;
  endfunction

  always @(negedge clk) begin
    pexp_t pe;
    iexp_t ie;
    if (lenet_v) begin
      n_v++;
      chk("v_expected", 32'(pq.size() > 0), 1);
      if (pq.size() > 0) begin
        pe = pq.pop_front();
        chk("pix", 32'(lenet_pix), 32'(pe.pix));
        chk("v_latency", cyc, pe.cyc);
      end
      last_v_cyc = cyc;
    end
    if (lenet_start) begin
      n_start++;
      chk("start_expected", 32'(iq.size() > 0), 1);
      if (iq.size() > 0) begin
        ie = iq.pop_front();
        chk("image_num", 32'(image_num), 32'(ie.id));
        chk("start_latency", cyc, ie.cyc);
      end
    end
    if (frame_done) begin
      n_done++;
      chk("done_latency", cyc, last_v_cyc + 1);
    end
    if (err_short_frame) n_err++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_st = n_start; s_v = n_v; s_dn = n_done; s_er = n_err;
  endtask

  task automatic deltas(input string tag, input int st, input int v, input int dn, input int er);
    chk({tag, "_starts"}, n_start - s_st, st);
    chk({tag, "_pixels"}, n_v - s_v, v);
    chk({tag, "_dones"},  n_done - s_dn, dn);
    chk({tag, "_errs"},   n_err - s_er, er);
  endtask

  task automatic send_lines(input int pat, input int nl, input bit acc, input int drop);
    pexp_t e;
    int rx, ry;
    for (int y = 0; y < nl; y++) begin
      if (y == drop) enable = 1'b0;
      for (int x = 0; x < P_SRC_W; x++) begin
        s_de  = 1'b1;
        s_pix = gen(pat, x, y);
        rx = x - P_X0;
        ry = y - P_Y0;
        if (acc && rx >= 0 && rx < P_OW * P_DS && ry >= 0 && ry < P_OH * P_DS &&
            (rx % P_DS) == P_DS - 1 && (ry % P_DS) == P_DS - 1) begin
          e.pix = exp_pix(pat, rx / P_DS, ry / P_DS);
          e.cyc = cyc + 2;
          pq.push_back(e);
        end
        step();
      end
      s_de  = 1'b0;
      s_pix = '0;
      repeat (HGAP) step();
    end
  endtask

  task automatic send_frame(input int pat, input int nl, input bit en, input int drop);
    iexp_t ie;
    s_vsync = 1'b1;
    enable  = en;
    s_de    = 1'b0;
    if (en) begin
      ie.id  = m_fc;
      ie.cyc = cyc + 1;
      iq.push_back(ie);
      m_fc = m_fc + 4'd1;
    end
    step();
    s_vsync = 1'b0;
    repeat (2) step();
    send_lines(pat, nl, en, drop);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_start", 32'(lenet_start), 0);
    chk("rst_v",     32'(lenet_v), 0);
    chk("rst_pix",   32'(lenet_pix), 0);
    chk("rst_img",   32'(image_num), 0);
    chk("rst_done",  32'(frame_done), 0);
    chk("rst_err",   32'(err_short_frame), 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Short frame (20 ROI lines) then a restart that completes normally
    g_seed = 3;
    snap();
    send_frame(3, P_Y0 + 20, 1'b1, -1);
    send_frame(0, P_SRC_H, 1'b1, -1);
    deltas("short", 2, 40 + P_NPIX, 1, 1);

    snap(); send_frame(1, P_SRC_H, 1'b1, -1); deltas("ramp", 1, P_NPIX, 1, 0);
    snap(); send_frame(2, P_SRC_H, 1'b1, -1); deltas("block", 1, P_NPIX, 1, 0);
    g_seed = 7;
    snap(); send_frame(3, P_SRC_H, 1'b1, -1); deltas("rand", 1, P_NPIX, 1, 0);
    snap(); send_frame(3, P_SRC_H, 1'b0, -1); deltas("disabled", 0, 0, 0, 0);
    snap(); send_frame(4, P_SRC_H, 1'b1, 10); deltas("en_drop", 1, P_NPIX, 1, 0);
    g_seed = 11;
    snap(); send_frame(3, P_SRC_H, 1'b1, -1); deltas("after_dis", 1, P_NPIX, 1, 0);

    // Asynchronous reset in the middle of a frame
    send_frame(3, 15, 1'b1, -1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_start", 32'(lenet_start), 0);
    chk("mid_rst_v",     32'(lenet_v), 0);
    chk("mid_rst_pix",   32'(lenet_pix), 0);
    chk("mid_rst_img",   32'(image_num), 0);
    chk("mid_rst_done",  32'(frame_done), 0);
    chk("mid_rst_err",   32'(err_short_frame), 0);
    step(); step();
    rst_n = 1'b1;
    pq.delete();
    iq.delete();
    m_fc = '0;
    snap();
    send_lines(3, P_SRC_H - 15, 1'b0, -1);
    deltas("post_rst", 0, 0, 0, 0);

    snap();
    for (int i = 0; i < 17; i++) begin
      g_seed = 20 + i;
      send_frame((i % 3 == 0) ? 0 : 3, P_SRC_H, 1'b1, -1);
    end
    deltas("seq17", 17, 17 * P_NPIX, 17, 0);

    for (int i = 0; i < 100 && (pq.size() > 0 || iq.size() > 0); i++) step();
    chk("pix_queue_empty", pq.size(), 0);
    chk("img_queue_empty", iq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
